cei_mochila_csr_obi_responder: RTL and testbench

// - OBI responder (slave end) for the SAFE_WRAPPER_CSR window of the system xbar (slave idx 4).
// - Holds a small 32-bit CSR file: CTRL, STATUS, scratch registers and an access counter.
// - Accepts one request per cycle and returns rvalid/rdata a fixed RESP_LATENCY cycles later.
// - Drives control bits into the safe wrapper and samples its status.

---
 rtl/cei_mochila_pkg.sv | 44 ++++
 rtl/cei_mochila_resp_pipe.sv | 43 ++++
 rtl/cei_mochila_csr_obi_responder.sv | 143 ++++++++++++++
 tb/tb_cei_mochila_csr_obi_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cei_mochila_pkg.sv
// Shared definitions for the cei_mochila safe-wrapper CSR slice.
// Holds the CSR window base, the register index map, the CTRL lock bit,
// the error read pattern, the response payload struct and a byte-merge helper.
package cei_mochila_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [ADDR_W-1:0] SAFE_WRAPPER_CSR_START_ADDRESS = 32'hF001_0000;

    // Register index map; ACC_CNT always occupies the last slot of the window.
    localparam int unsigned SAFE_WRAPPER_CSR_CTRL_IDX   = 0;
    localparam int unsigned SAFE_WRAPPER_CSR_STATUS_IDX = 1;

    function automatic int unsigned safe_wrapper_csr_acc_cnt_idx(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

    localparam int unsigned CTRL_LOCK_BIT = 0;

    localparam logic [DATA_W-1:0] ERROR_RDATA = 32'hBADA_CCE5;

    // One response beat travelling down the response pipeline.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } obi_resp_t;

    // Merge new write data into an old word under a byte-enable mask.
    function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cei_mochila_resp_pipe.sv
// Fixed-latency response shift pipeline.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (flushes all stages)
//   in_valid, in_resp    response entering stage 0 at the accept edge
//   out_valid, out_resp  registered output of the last stage
// Idle stages carry an all-zero payload so the outputs read 0 when no response is valid.
module cei_mochila_resp_pipe
    import cei_mochila_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      in_valid,
    input  obi_resp_t in_resp,
    output logic      out_valid,
    output obi_resp_t out_resp
);

    logic      valid_q [LATENCY];
    obi_resp_t resp_q  [LATENCY];

    // Shift register; stage 0 is loaded with a zero payload when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                valid_q[i] <= 1'b0;
                resp_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            resp_q[0]  <= in_valid ? in_resp : '0;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_resp  = resp_q[LATENCY-1];

endmodule

// File: rtl/cei_mochila_csr_obi_responder.sv
// OBI responder for the safe-wrapper CSR window.
// Holds CTRL (with sticky LOCK), a registered copy of the wrapper status,
// scratch registers and a free-running count of accepted requests.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_i/gnt_o                     request / grant (grant mirrors request)
//   addr_i, we_i, be_i, wdata_i     request payload
//   rvalid_o, rdata_o, err_o        in-order response, RESP_LATENCY cycles after accept
//   status_i                        safe-wrapper status, sampled every cycle
//   ctrl_o                          CTRL register contents
module cei_mochila_csr_obi_responder
    import cei_mochila_pkg::*;
#(
    parameter int unsigned        NUM_REGS     = 8,
    parameter int unsigned        RESP_LATENCY = 1,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = SAFE_WRAPPER_CSR_START_ADDRESS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    input  logic [DATA_W-1:0] status_i,
    output logic [DATA_W-1:0] ctrl_o
);

    localparam int unsigned       IDX_W        = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] WINDOW_BYTES = ADDR_W'(NUM_REGS * 4);
    localparam logic [IDX_W-1:0]  CTRL_IDX     = IDX_W'(SAFE_WRAPPER_CSR_CTRL_IDX);
    localparam logic [IDX_W-1:0]  STATUS_IDX   = IDX_W'(SAFE_WRAPPER_CSR_STATUS_IDX);
    localparam logic [IDX_W-1:0]  ACC_IDX      = IDX_W'(safe_wrapper_csr_acc_cnt_idx(NUM_REGS));
    localparam logic [IDX_W-1:0]  SCR_FIRST    = IDX_W'(2);
    localparam logic [IDX_W-1:0]  SCR_LAST     = IDX_W'(NUM_REGS - 2);
    localparam logic [DATA_W-1:0] LOCK_MASK    = DATA_W'(1) << CTRL_LOCK_BIT;

    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] acc_cnt_q;
    logic [DATA_W-1:0] scratch_q [NUM_REGS];

    logic              accept;
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic              addr_err;
    logic              is_ctrl;
    logic              is_status;
    logic              is_acc;
    logic              is_scratch;
    logic              locked;
    logic              wr_denied;
    logic              req_err;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;
    obi_resp_t         req_resp;
    obi_resp_t         pipe_resp;

    // Always ready: one request per cycle.
    assign gnt_o  = req_i;
    assign accept = req_i & gnt_o;

    // Address decode relative to the window base.
    assign off      = addr_i - BASE_ADDR;
    assign idx      = off[IDX_W+1:2];
    assign addr_err = (addr_i < BASE_ADDR) | (off >= WINDOW_BYTES) | (addr_i[1:0] != 2'b00);

    assign is_ctrl    = (idx == CTRL_IDX);
    assign is_status  = (idx == STATUS_IDX);
    assign is_acc     = (idx == ACC_IDX);
    assign is_scratch = (idx >= SCR_FIRST) && (idx <= SCR_LAST);
    assign locked     = ctrl_q[CTRL_LOCK_BIT];

    // Read-only targets always refuse writes; LOCK freezes CTRL and scratch.
    assign wr_denied = we_i & (is_status | is_acc | (locked & (is_ctrl | is_scratch)));
    assign req_err   = addr_err | wr_denied;
    assign wr_ok     = accept & we_i & ~req_err;

    // Read mux samples pre-edge state, so ACC_CNT returns its value before this access.
    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
            rd_data = ctrl_q;
        end else if (is_status) begin
            rd_data = status_q;
        end else if (is_acc) begin
            rd_data = acc_cnt_q;
        end else if (is_scratch) begin
            rd_data = scratch_q[idx];
        end
    end

    // Writes report zero data; errored reads report the error pattern.
    always_comb begin
        req_resp       = '0;
        req_resp.err   = req_err;
        req_resp.rdata = we_i ? '0 : (req_err ? ERROR_RDATA : rd_data);
    end

    // CSR state; writes commit at the accept edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= '0;
            status_q  <= '0;
            acc_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            status_q <= status_i;
            if (accept) begin
                acc_cnt_q <= acc_cnt_q + DATA_W'(1);
            end
            if (wr_ok && is_ctrl) begin
                ctrl_q <= apply_be(ctrl_q, wdata_i, be_i) | (ctrl_q & LOCK_MASK);
            end
            if (wr_ok && is_scratch) begin
                scratch_q[idx] <= apply_be(scratch_q[idx], wdata_i, be_i);
            end
        end
    end

    assign ctrl_o = ctrl_q;

    cei_mochila_resp_pipe #(
        .LATENCY (RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (accept),
        .in_resp   (req_resp),
        .out_valid (rvalid_o),
        .out_resp  (pipe_resp)
    );

    assign rdata_o = pipe_resp.rdata;
    assign err_o   = pipe_resp.err;

endmodule

// File: tb/tb_cei_mochila_csr_obi_responder.sv
// Self-checking bench for cei_mochila_csr_obi_responder (NUM_REGS=8, RESP_LATENCY=3).
module tb_cei_mochila_csr_obi_responder;

    localparam int          LAT      = 3;
    localparam logic [31:0] BAD      = 32'hBADA_CCE5;
    localparam logic [31:0] STAT_VAL = 32'hA5A5_5A5A;

    logic        clk;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] status_i;
    logic [31:0] ctrl_o;

    cei_mochila_csr_obi_responder #(
        .NUM_REGS     (8),
        .RESP_LATENCY (LAT),
        .BASE_ADDR    (32'hF001_0000)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .status_i (status_i),
        .ctrl_o   (ctrl_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one request for exactly one cycle; optionally register its expected response.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         input bit track);
        exp_t e;
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = w;
        be_i    = b;
        wdata_i = d;
        #1;
        chk("gnt", 32'(gnt_o), 32'd1);
        @(posedge clk);
        #1;
        if (track) begin
            e.rdata = er;
            e.err   = ee;
            e.acc   = cyc;
            sb.push_back(e);
        end
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    // Response monitor: in-order match, latency check, spurious and missing responses.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni) begin
            if (rvalid_o) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rvalid: got rdata %08h err %0b with nothing outstanding",
                             rdata_o, err_o);
                end else begin
                    e = sb.pop_front();
                    if (rdata_o !== e.rdata || err_o !== e.err || (cyc - e.acc) != LAT - 1) begin
                        n_bad++;
                        $display("FAIL response: got rdata %08h err %0b delay %0d expected rdata %08h err %0b delay %0d",
                                 rdata_o, err_o, cyc - e.acc, e.rdata, e.err, LAT - 1);
                    end
                end
            end else if (sb.size() != 0 && (cyc - sb[0].acc) >= LAT - 1) begin
                n_vec++;
                n_bad++;
                e = sb.pop_front();
                $display("FAIL missing_rvalid: got none expected rdata %08h err %0b", e.rdata, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    vec_t vecs[18];
    int   rv_cnt;

    initial begin
        vecs[0]  = '{32'hF001_0008, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{32'hF001_0008, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'hF001_0008, 1'b1, 4'h5, 32'h1122_3344, 32'h0,         1'b0};
        vecs[3]  = '{32'hF001_0008, 1'b0, 4'hF, 32'h0,         32'hDE22_BE44, 1'b0};
        vecs[4]  = '{32'hF001_0020, 1'b0, 4'hF, 32'h0,         BAD,           1'b1};
        vecs[5]  = '{32'hF001_0002, 1'b0, 4'hF, 32'h0,         BAD,           1'b1};
        vecs[6]  = '{32'hF000_FFFC, 1'b0, 4'hF, 32'h0,         BAD,           1'b1};
        vecs[7]  = '{32'hF001_0004, 1'b1, 4'hF, 32'h0000_1234, 32'h0,         1'b1};
        vecs[8]  = '{32'hF001_001C, 1'b1, 4'hF, 32'h0000_1234, 32'h0,         1'b1};
        vecs[9]  = '{32'hF001_000C, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[10] = '{32'hF001_000C, 1'b0, 4'hF, 32'h0,         32'h0,         1'b0};
        vecs[11] = '{32'hF001_0004, 1'b0, 4'hF, 32'h0,         STAT_VAL,      1'b0};
        vecs[12] = '{32'hF001_001C, 1'b0, 4'hF, 32'h0,         32'd22,        1'b0};
        vecs[13] = '{32'hF001_0000, 1'b1, 4'hF, 32'h0000_0001, 32'h0,         1'b0};
        vecs[14] = '{32'hF001_0008, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[15] = '{32'hF001_0000, 1'b1, 4'hF, 32'h0000_0002, 32'h0,         1'b1};
        vecs[16] = '{32'hF001_0000, 1'b0, 4'hF, 32'h0,         32'h0000_0001, 1'b0};
        vecs[17] = '{32'hF001_0008, 1'b0, 4'hF, 32'h0,         32'hDE22_BE44, 1'b0};

        rst_ni   = 1'b0;
        req_i    = 1'b0;
        addr_i   = '0;
        we_i     = 1'b0;
        be_i     = '0;
        wdata_i  = '0;
        status_i = STAT_VAL;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ctrl_o", ctrl_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // ACC_CNT from reset: back-to-back reads count 0..9.
        for (int i = 0; i < 10; i++) begin
            issue(32'hF001_001C, 1'b0, 4'hF, 32'h0, 32'(i), 1'b0, 1'b1);
        end

        // Table vectors, back-to-back (ACC_CNT read in vec 12 sees 10 + 12 prior accepts).
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
        end

        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
        chk("idle_rdata", rdata_o, 32'd0);
        chk("idle_err", 32'(err_o), 32'd0);
        chk("locked_ctrl_o", ctrl_o, 32'h0000_0001);

        // Reset with two requests in flight: no response may emerge.
        issue(32'hF001_0008, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(32'hF001_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #20;
        chk("inflight_rst_ctrl_o", ctrl_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        rv_cnt = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (rvalid_o) rv_cnt++;
        end
        chk("inflight_dropped", 32'(rv_cnt), 32'd0);
        @(posedge clk);
        #1;
        issue(32'hF001_001C, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(32'hF001_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(32'hF001_0008, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(32'hF001_0010, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("post_rst_outstanding", 32'(sb.size()), 32'd0);
        chk("post_rst_ctrl_o", ctrl_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
